tri_host: RTL and testbench

TRI_HOST -- requirements
Module: tri_host

---
 rtl/tri_host.sv | 120 ++++++++++++
 tb/tb_tri_host.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tri_host.sv
// tri_host: queues triangles, sends their vertices to a renderer and reports per-triangle pixel counts.
// Define TRI_HOST_BBOX_EN to also report the bounding box of the counted pixels.
module tri_host #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tri_valid,
    output logic        tri_ready,
    input  logic [17:0] tri_xy,
    output logic        nt,
    output logic [2:0]  xi,
    output logic [2:0]  yi,
    input  logic        busy,
    input  logic        po,
    input  logic [2:0]  xo,
    input  logic [2:0]  yo,
    output logic        done,
    output logic [6:0]  pix_cnt,
    output logic [15:0] tri_cnt,
    output logic [11:0] bbox
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, WAIT, RUN, REPORT} state_t;
    state_t state_q, state_d;
    logic [17:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic [17:0] head;
    logic empty, full, push, pop, start, count_en;
    logic nt_q, nt_d, done_q;
    logic [2:0] xi_q, xi_d, yi_q, yi_d;
    logic [6:0] cnt_q, cnt_d, pix_q;
    logic [15:0] tri_q;
    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = wr_q == rd_q;
    assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign tri_ready = !full;
    assign push = tri_valid && !full;
    assign pop = state_q == SEND2;
    assign head = mem_q[rd_q[AW-1:0]];
    assign start = (state_q == IDLE) && !empty;
    assign count_en = po && (state_q == SEND1 || state_q == SEND2 || state_q == WAIT || state_q == RUN);
    assign nt = nt_q;
    assign xi = xi_q;
    assign yi = yi_q;
    assign done = done_q;
    assign pix_cnt = pix_q;
    assign tri_cnt = tri_q;
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = empty ? IDLE : SEND0;
            SEND0:   state_d = SEND1;
            SEND1:   state_d = SEND2;
            SEND2:   state_d = WAIT;
            WAIT:    state_d = busy ? RUN : WAIT;
            RUN:     state_d = busy ? RUN : REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        nt_d = state_d == SEND0;
        xi_d = (state_d == SEND0) ? head[17:15] : (state_d == SEND1) ? head[11:9] : (state_d == SEND2) ? head[5:3] : 3'd0;
        yi_d = (state_d == SEND0) ? head[14:12] : (state_d == SEND1) ? head[8:6] : (state_d == SEND2) ? head[2:0] : 3'd0;
        cnt_d = start ? 7'd0 : (count_en && cnt_q != 7'd64) ? cnt_q + 7'd1 : cnt_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wr_q <= '0;
            rd_q <= '0;
            nt_q <= 1'b0;
            xi_q <= 3'd0;
            yi_q <= 3'd0;
            done_q <= 1'b0;
            cnt_q <= 7'd0;
            pix_q <= 7'd0;
            tri_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop) rd_q <= rd_q + (AW+1)'(1);
            nt_q <= nt_d;
            xi_q <= xi_d;
            yi_q <= yi_d;
            done_q <= state_d == REPORT;
            cnt_q <= cnt_d;
            if (state_d == REPORT) begin
                pix_q <= cnt_d;
                tri_q <= tri_q + 16'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= tri_xy;
    end
`ifdef TRI_HOST_BBOX_EN
    logic [2:0] xmin_q, xmin_d, ymin_q, ymin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    logic [11:0] bbox_q;
    always_comb begin
        xmin_d = start ? 3'd7 : (count_en && xo < xmin_q) ? xo : xmin_q;
        ymin_d = start ? 3'd7 : (count_en && yo < ymin_q) ? yo : ymin_q;
        xmax_d = start ? 3'd0 : (count_en && xo > xmax_q) ? xo : xmax_q;
        ymax_d = start ? 3'd0 : (count_en && yo > ymax_q) ? yo : ymax_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {xmin_q, ymin_q, xmax_q, ymax_q} <= 12'd0;
            bbox_q <= 12'd0;
        end else begin
            {xmin_q, ymin_q, xmax_q, ymax_q} <= {xmin_d, ymin_d, xmax_d, ymax_d};
            if (state_d == REPORT) bbox_q <= {xmin_d, ymin_d, xmax_d, ymax_d};
        end
    end
    assign bbox = bbox_q;
`else
    logic unused_xy;
    assign unused_xy = ^{xo, yo};
    assign bbox = 12'd0;
`endif
endmodule

// File: tb/tb_tri_host.sv
// tb_tri_host: directed stimulus with queued expectations checked by independent monitors.
// Honours TRI_HOST_BBOX_EN for the expected bounding box.
module tb_tri_host;
    logic        clk = 0, reset = 0, tri_valid = 0, busy = 0, po = 0;
    logic [17:0] tri_xy = 0;
    logic [2:0]  xo = 0, yo = 0;
    logic        tri_ready, nt, done;
    logic [2:0]  xi, yi;
    logic [6:0]  pix_cnt;
    logic [15:0] tri_cnt;
    logic [11:0] bbox;
    int checks = 0, errors = 0, sends = 0, rendered = 0;
    logic [15:0] tri_exp = 0;
    logic [17:0] exp_tri [$];
    logic [34:0] exp_rep [$];
    logic [17:0] vec [5] = '{18'o123456, 18'o765432, 18'o012345, 18'o567012, 18'o704152};

    tri_host #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_xy(tri_xy),
        .nt(nt), .xi(xi), .yi(yi), .busy(busy), .po(po), .xo(xo), .yo(yo),
        .done(done), .pix_cnt(pix_cnt), .tri_cnt(tri_cnt), .bbox(bbox)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [17:0] xy);
        int t = 0;
        @(negedge clk);
        while (!tri_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("push_wait", 32'(t < 500), 1);
        tri_valid = 1;
        tri_xy = xy;
        exp_tri.push_back(xy);
        @(posedge clk);
        #1 tri_valid = 0;
    endtask

    // Busy for 64 cycles (first one lands in WAIT), po from pat, then the busy-fall cycle with po=fall.
    task automatic render(input logic [63:0] pat, input logic fall);
        int n = 0;
        int t = 0;
        logic [6:0] iv;
        logic [2:0] mnx = 3'd7, mny = 3'd7, mxx = 3'd0, mxy = 3'd0;
        logic [11:0] bb;
        logic on;
        for (int i = 0; i <= 64; i++) begin
            iv = 7'(i);
            on = (i < 64) ? pat[i] : fall;
            if (on) begin
                n++;
                if (iv[2:0] < mnx) mnx = iv[2:0];
                if (iv[5:3] < mny) mny = iv[5:3];
                if (iv[2:0] > mxx) mxx = iv[2:0];
                if (iv[5:3] > mxy) mxy = iv[5:3];
            end
        end
`ifdef TRI_HOST_BBOX_EN
        bb = {mnx, mny, mxx, mxy};
`else
        bb = 12'd0;
`endif
        tri_exp++;
        exp_rep.push_back({7'(n > 64 ? 64 : n), tri_exp, bb});
        while (sends <= rendered && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("send_wait", 32'(t < 500), 1);
        rendered++;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            iv = 7'(i);
            busy = 1;
            po = pat[i];
            xo = iv[2:0];
            yo = iv[5:3];
            @(negedge clk);
        end
        busy = 0;
        po = fall;
        xo = 0;
        yo = 0;
        @(negedge clk);
        po = 0;
    endtask

    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (nt === 1'b1) begin
                if (exp_tri.size() == 0) chk("nt_unexpected", 32'(nt), 0);
                else begin
                    e = exp_tri.pop_front();
                    chk("send0_x", 32'(xi), 32'(e[17:15]));
                    chk("send0_y", 32'(yi), 32'(e[14:12]));
                    @(negedge clk);
                    chk("send1_nt", 32'(nt), 0);
                    chk("send1_x", 32'(xi), 32'(e[11:9]));
                    chk("send1_y", 32'(yi), 32'(e[8:6]));
                    @(negedge clk);
                    chk("send2_nt", 32'(nt), 0);
                    chk("send2_x", 32'(xi), 32'(e[5:3]));
                    chk("send2_y", 32'(yi), 32'(e[2:0]));
                    sends++;
                end
            end
        end
    end

    initial begin
        logic [34:0] r;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_rep.size() == 0) chk("done_unexpected", 32'(done), 0);
                else begin
                    r = exp_rep.pop_front();
                    chk("pix_cnt", 32'(pix_cnt), 32'(r[34:28]));
                    chk("tri_cnt", 32'(tri_cnt), 32'(r[27:12]));
                    chk("bbox", 32'(bbox), 32'(r[11:0]));
                    @(negedge clk);
                    chk("done_pulse", 32'(done), 0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outputs", 32'({nt, xi, yi, done}), 0);
        chk("rst_counts", 32'({pix_cnt, tri_cnt}), 0);
        chk("rst_bbox", 32'(bbox), 0);
        chk("rst_ready", 32'(tri_ready), 1);
        reset = 1;
        @(negedge clk);
        chk("post_rst_nt", 32'(nt), 0);
        chk("post_rst_ready", 32'(tri_ready), 1);
        // Latency and vertex order for {1,1,5,3,1,6}; 9 busy pixels plus the busy-fall pixel.
        push(18'o115316);
        @(negedge clk);
        chk("lat_early_nt", 32'(nt), 0);
        @(negedge clk);
        chk("lat_nt", 32'(nt), 1);
        render(64'h1FF, 1'b1);
        // Five triangles into a four-deep queue.
        for (int k = 0; k < 4; k++) push(vec[k]);
        @(negedge clk);
        chk("ready_full", 32'(tri_ready), 0);
        push(vec[4]);
        for (int k = 0; k < 5; k++) render((64'd1 << (k + 1)) - 64'd1, 1'b0);
        // Every busy cycle lit.
        push(18'o777000);
        render({64{1'b1}}, 1'b0);
        // po also high in IDLE, SEND and WAIT: counter must saturate.
        po = 1;
        xo = 0;
        yo = 0;
        repeat (3) @(negedge clk);
        push(18'o070707);
        render({64{1'b1}}, 1'b1);
        // No pixels at all.
        push(18'o101010);
        render(64'd0, 1'b0);
        // Pixels only at (2,3) and (6,5).
        push(18'o234567);
        render((64'd1 << 26) | (64'd1 << 46), 1'b0);
        // Reset mid-RUN with two triangles still queued.
        push(18'o111111);
        push(18'o222222);
        push(18'o333333);
        begin
            int t = 0;
            while (sends <= rendered && t < 500) begin
                @(negedge clk);
                t++;
            end
            chk("abort_send_wait", 32'(t < 500), 1);
        end
        rendered++;
        @(negedge clk);
        busy = 1;
        po = 1;
        repeat (10) @(negedge clk);
        reset = 0;
        exp_tri.delete();
        tri_exp = 0;
        #1;
        chk("abort_ready", 32'(tri_ready), 1);
        chk("abort_counts", 32'({pix_cnt, tri_cnt}), 0);
        busy = 0;
        po = 0;
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_nt", 32'(nt), 0);
            chk("abort_done", 32'(done), 0);
        end
        chk("abort_ready_after", 32'(tri_ready), 1);
        push(18'o246135);
        render(64'h7, 1'b0);
        repeat (5) @(negedge clk);
        chk("tri_queue_drained", 32'(exp_tri.size()), 0);
        chk("report_queue_drained", 32'(exp_rep.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
